spi_master_arbiter: RTL and testbench

Shares one SPI master engine between NUM_REQ independent requesters using round-robin arbitration.
Each requester presents a 32-bit MOSI word plus its own SPI mode, SCK speed and word-length configuration.
The arbiter latches the winner's request, drives the master's start, config and data inputs, and tracks the master's busy flag through the whole frame.
It then returns the captured MISO word to the winner with a one-cycle acknowledge. It sits between the register/bus-side clients and the SPI master.

---
 rtl/spi_master_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI master engine between NUM_REQ requesters.
// Optional watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module spi_master_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                    GCLK,
  input  logic                    RST,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [6*NUM_REQ-1:0]    cfg_i,
  input  logic [32*NUM_REQ-1:0]   wr_data_i,
  output logic [NUM_REQ-1:0]      gnt_o,
  output logic [NUM_REQ-1:0]      ack_o,
  output logic [31:0]             rd_data_o,
  output logic                    err_o,
  output logic                    spi_start_o,
  output logic [1:0]              spi_mode_o,
  output logic [1:0]              spi_speed_o,
  output logic [1:0]              spi_word_len_o,
  output logic [31:0]             spi_mosi_data_o,
  input  logic                    spi_busy_i,
  input  logic [31:0]             spi_miso_data_i
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StLaunch,
    StActive,
    StDone
  } state_e;

  state_e             r_state, w_state_d;
  logic [IdxW-1:0]    r_ptr, w_ptr_d;
  logic [IdxW-1:0]    r_win, w_win_d;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_d;
  logic [NUM_REQ-1:0] r_ack, w_ack_d;
  logic [31:0]        r_rd, w_rd_d;
  logic               r_start, w_start_d;
  logic [1:0]         r_mode, w_mode_d;
  logic [1:0]         r_speed, w_speed_d;
  logic [1:0]         r_len, w_len_d;
  logic [31:0]        r_mosi, w_mosi_d;

  logic               w_found;
  logic [IdxW-1:0]    w_pick;
  logic [IdxW-1:0]    w_cand;
  int unsigned        w_k;
  logic [5:0]         w_cfg_sel;
  logic [31:0]        w_data_sel;
  logic               w_timeout;
  logic               w_to_fire;

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_k     = 0;
    w_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_k = 32'(r_ptr) + i;
      if (w_k >= NUM_REQ) w_k = w_k - NUM_REQ;
      w_cand = IdxW'(w_k);
      if (!w_found && req_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_cfg_sel  = '0;
    w_data_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IdxW'(i) == w_pick) begin
        w_cfg_sel  = cfg_i[6*i +: 6];
        w_data_sel = wr_data_i[32*i +: 32];
      end
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [31:0] TimeoutLast = 32'(TIMEOUT_CYCLES) - 32'd1;

  logic [31:0] r_cnt, w_cnt_d;
  logic        r_err, w_err_d;

  assign w_timeout = ((r_state == StLaunch) || (r_state == StActive)) && (r_cnt == TimeoutLast);
`else
  assign w_timeout = 1'b0;
`endif

  // Watchdog only fires when the awaited busy transition has not happened this cycle.
  assign w_to_fire = w_timeout &&
                     (((r_state == StLaunch) && !spi_busy_i) ||
                      ((r_state == StActive) && spi_busy_i));

  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_win_d   = r_win;
    w_gnt_d   = r_gnt;
    w_ack_d   = '0;
    w_rd_d    = r_rd;
    w_start_d = r_start;
    w_mode_d  = r_mode;
    w_speed_d = r_speed;
    w_len_d   = r_len;
    w_mosi_d  = r_mosi;
    unique case (r_state)
      StIdle: begin
        // A stale busy from the master blocks new grants.
        if (w_found && !spi_busy_i) begin
          w_win_d   = w_pick;
          w_gnt_d   = NUM_REQ'(1) << w_pick;
          w_mode_d  = w_cfg_sel[5:4];
          w_speed_d = w_cfg_sel[3:2];
          w_len_d   = w_cfg_sel[1:0];
          w_mosi_d  = w_data_sel;
          w_start_d = 1'b1;
          w_state_d = StLaunch;
        end
      end
      StLaunch: begin
        if (spi_busy_i) begin
          w_start_d = 1'b0;
          w_state_d = StActive;
        end else if (w_to_fire) begin
          w_start_d = 1'b0;
          w_rd_d    = '0;
          w_ack_d   = r_gnt;
          w_state_d = StDone;
        end
      end
      StActive: begin
        if (!spi_busy_i) begin
          w_rd_d    = spi_miso_data_i;
          w_ack_d   = r_gnt;
          w_state_d = StDone;
        end else if (w_to_fire) begin
          w_start_d = 1'b0;
          w_rd_d    = '0;
          w_ack_d   = r_gnt;
          w_state_d = StDone;
        end
      end
      StDone: begin
        w_gnt_d   = '0;
        w_ptr_d   = (r_win == IdxW'(NUM_REQ - 1)) ? '0 : r_win + IdxW'(1);
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_win   <= '0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_rd    <= '0;
      r_start <= 1'b0;
      r_mode  <= '0;
      r_speed <= '0;
      r_len   <= '0;
      r_mosi  <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_win   <= w_win_d;
      r_gnt   <= w_gnt_d;
      r_ack   <= w_ack_d;
      r_rd    <= w_rd_d;
      r_start <= w_start_d;
      r_mode  <= w_mode_d;
      r_speed <= w_speed_d;
      r_len   <= w_len_d;
      r_mosi  <= w_mosi_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Counter restarts on entry to LAUNCH and to ACTIVE.
  always_comb begin
    w_cnt_d = r_cnt;
    w_err_d = r_err;
    if ((r_state == StIdle) && (w_state_d == StLaunch)) begin
      w_cnt_d = '0;
    end else if ((r_state == StLaunch) && (w_state_d == StActive)) begin
      w_cnt_d = '0;
    end else if ((r_state == StLaunch) || (r_state == StActive)) begin
      w_cnt_d = r_cnt + 32'd1;
    end
    if (w_to_fire) begin
      w_err_d = 1'b1;
    end else if (r_state == StDone) begin
      w_err_d = 1'b0;
    end
  end

  always_ff @(posedge GCLK or negedge RST) begin
    if (!RST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_err <= w_err_d;
    end
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign gnt_o           = r_gnt;
  assign ack_o           = r_ack;
  assign rd_data_o       = r_rd;
  assign spi_start_o     = r_start;
  assign spi_mode_o      = r_mode;
  assign spi_speed_o     = r_speed;
  assign spi_word_len_o  = r_len;
  assign spi_mosi_data_o = r_mosi;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter: behavioural SPI master plus round-robin reference model.
// Define SPI_ARB_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=100.
`timescale 1ns/1ps
module tb_spi_master_arbiter;

  localparam int unsigned N = 3;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int unsigned TO = 100;
`else
  localparam int unsigned TO = 65535;
`endif

  logic            GCLK;
  logic            RST;
  logic [N-1:0]    req_i;
  logic [6*N-1:0]  cfg_i;
  logic [32*N-1:0] wr_data_i;
  logic [N-1:0]    gnt_o;
  logic [N-1:0]    ack_o;
  logic [31:0]     rd_data_o;
  logic            err_o;
  logic            spi_start_o;
  logic [1:0]      spi_mode_o;
  logic [1:0]      spi_speed_o;
  logic [1:0]      spi_word_len_o;
  logic [31:0]     spi_mosi_data_o;
  logic            spi_busy_i;
  logic [31:0]     spi_miso_data_i;

  spi_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .GCLK(GCLK), .RST(RST), .req_i(req_i), .cfg_i(cfg_i), .wr_data_i(wr_data_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .rd_data_o(rd_data_o), .err_o(err_o),
    .spi_start_o(spi_start_o), .spi_mode_o(spi_mode_o), .spi_speed_o(spi_speed_o),
    .spi_word_len_o(spi_word_len_o), .spi_mosi_data_o(spi_mosi_data_o),
    .spi_busy_i(spi_busy_i), .spi_miso_data_i(spi_miso_data_i)
  );

  initial GCLK = 1'b0;
  always #5 GCLK = ~GCLK;

  typedef struct {
    int          idx;
    logic [1:0]  mode;
    logic [1:0]  speed;
    logic [1:0]  len;
    logic [31:0] mosi;
    logic        start;
    int          cyc;
  } gev_t;

  typedef struct {
    int          idx;
    logic [31:0] rd;
    logic        err;
    logic        start;
    logic [N-1:0] gnt;
    int          cyc;
  } aev_t;

  gev_t        gq[$];
  aev_t        aq[$];
  int          n_cmp, n_fail, cyc, model_ptr;
  bit          m_en;
  int          m_cnt, m_len_fix;
  logic [31:0] m_key, m_mosi;
  logic [N-1:0] prev_gnt;

  function automatic int oh_idx(logic [N-1:0] v);
    if ($countones(v) != 1) return -1;
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Reference arbitration: first pending requester at or after ptr, wrapping.
  function automatic int rr_pick(logic [N-1:0] pend, int ptr);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (ptr + i) % N;
      if (pend[k]) return k;
    end
    return -1;
  endfunction

  // One cycle: record grant/ack events, requesters drop on ack, master model responds.
  task automatic step();
    gev_t ge;
    aev_t ae;
    @(negedge GCLK);
    cyc++;
    if (gnt_o != '0 && prev_gnt == '0) begin
      ge.idx = oh_idx(gnt_o); ge.mode = spi_mode_o; ge.speed = spi_speed_o;
      ge.len = spi_word_len_o; ge.mosi = spi_mosi_data_o; ge.start = spi_start_o; ge.cyc = cyc;
      gq.push_back(ge);
    end
    prev_gnt = gnt_o;
    if (ack_o != '0) begin
      ae.idx = oh_idx(ack_o); ae.rd = rd_data_o; ae.err = err_o; ae.start = spi_start_o;
      ae.gnt = gnt_o; ae.cyc = cyc;
      aq.push_back(ae);
      req_i = req_i & ~ack_o;
    end
    if (m_en) begin
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          spi_miso_data_i = m_mosi ^ m_key;
          spi_busy_i = 1'b0;
        end
      end else if (spi_start_o && !spi_busy_i) begin
        m_mosi = spi_mosi_data_o;
        m_cnt = (m_len_fix > 0) ? m_len_fix : int'($urandom_range(1, 8));
        spi_busy_i = 1'b1;
      end
    end
  endtask

  task automatic wait_acks(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (aq.size() < n && b < budget) begin step(); b++; end
    ok = (aq.size() >= n);
  endtask

  task automatic wait_grants(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (gq.size() < n && b < budget) begin step(); b++; end
    ok = (gq.size() >= n);
  endtask

  task automatic do_reset();
    RST = 1'b0; req_i = '0; spi_busy_i = 1'b0; spi_miso_data_i = '0; m_cnt = 0; m_en = 1'b1;
    repeat (2) @(negedge GCLK);
    RST = 1'b1; prev_gnt = '0; model_ptr = 0;
    gq.delete(); aq.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge GCLK);
    for (int pass = 0; pass < 2; pass++) begin
      n_cmp++; if (gnt_o !== '0) begin n_fail++; $display("FAIL reset_gnt[%0d]: got %b want 0", pass, gnt_o); end
      n_cmp++; if (ack_o !== '0) begin n_fail++; $display("FAIL reset_ack[%0d]: got %b want 0", pass, ack_o); end
      n_cmp++; if (rd_data_o !== '0) begin n_fail++; $display("FAIL reset_rd[%0d]: got %h want 0", pass, rd_data_o); end
      n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL reset_err[%0d]: got %b want 0", pass, err_o); end
      n_cmp++; if (spi_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start[%0d]: got %b want 0", pass, spi_start_o); end
      n_cmp++; if ({spi_mode_o, spi_speed_o, spi_word_len_o} !== 6'd0) begin
        n_fail++; $display("FAIL reset_cfg[%0d]: got %b want 0", pass, {spi_mode_o, spi_speed_o, spi_word_len_o}); end
      n_cmp++; if (spi_mosi_data_o !== '0) begin n_fail++; $display("FAIL reset_mosi[%0d]: got %h want 0", pass, spi_mosi_data_o); end
      if (pass == 0) begin RST = 1'b1; step(); end
    end
  endtask

  task automatic test_single();
    bit ok;
    int c0;
    gq.delete(); aq.delete();
    m_len_fix = 40; m_key = 32'hA5A5_0FCC;
    wr_data_i[31:0] = 32'hA5A5_0F0F; cfg_i[5:0] = 6'b01_10_10;
    req_i = 3'b001; c0 = cyc;
    wait_grants(1, 20, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_grant: got no grant want grant"); end
    if (ok) begin
      n_cmp++; if (gq[0].cyc - c0 != 1) begin n_fail++; $display("FAIL single_latency: got %0d want 1", gq[0].cyc - c0); end
      n_cmp++; if (gq[0].idx != 0) begin n_fail++; $display("FAIL single_gnt: got %0d want 0", gq[0].idx); end
      n_cmp++; if ({gq[0].mode, gq[0].speed, gq[0].len} !== 6'b01_10_10) begin
        n_fail++; $display("FAIL single_cfg: got %b want 011010", {gq[0].mode, gq[0].speed, gq[0].len}); end
      n_cmp++; if (gq[0].mosi !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_mosi: got %h want a5a50f0f", gq[0].mosi); end
      n_cmp++; if (gq[0].start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b want 1", gq[0].start); end
    end
    cfg_i[5:0] = 6'b10_01_01; wr_data_i[31:0] = $urandom;
    repeat (5) step();
    n_cmp++; if ({spi_mode_o, spi_speed_o, spi_word_len_o} !== 6'b01_10_10) begin
      n_fail++; $display("FAIL single_cfg_hold: got %b want 011010", {spi_mode_o, spi_speed_o, spi_word_len_o}); end
    n_cmp++; if (spi_mosi_data_o !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL single_mosi_hold: got %h want a5a50f0f", spi_mosi_data_o); end
    wait_acks(1, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL single_ack: got no ack want ack"); end
    if (ok) begin
      n_cmp++; if (aq[0].idx != 0) begin n_fail++; $display("FAIL single_ack_idx: got %0d want 0", aq[0].idx); end
      n_cmp++; if (aq[0].rd !== 32'h0000_00C3) begin n_fail++; $display("FAIL single_rd: got %h want 000000c3", aq[0].rd); end
      n_cmp++; if (aq[0].err !== 1'b0) begin n_fail++; $display("FAIL single_err: got %b want 0", aq[0].err); end
      n_cmp++; if (aq[0].gnt !== 3'b001) begin n_fail++; $display("FAIL single_gnt_done: got %b want 001", aq[0].gnt); end
    end
    step();
    n_cmp++; if (gnt_o !== '0 || ack_o !== '0) begin n_fail++; $display("FAIL single_idle: got gnt %b ack %b want 0 0", gnt_o, ack_o); end
    n_cmp++; if (rd_data_o !== 32'h0000_00C3) begin n_fail++; $display("FAIL single_rd_hold: got %h want 000000c3", rd_data_o); end
    model_ptr = 1;
  endtask

  task automatic test_alternate();
    bit ok;
    int exp[$];
    int p;
    logic [N-1:0] pend;
    do_reset();
    m_len_fix = 0; m_key = $urandom;
    for (int k = 0; k < N; k++) begin cfg_i[6*k +: 6] = 6'($urandom); wr_data_i[32*k +: 32] = $urandom; end
    p = model_ptr;
    for (int round = 0; round < 2; round++) begin
      pend = 3'b011;
      while (pend != '0) begin int k; k = rr_pick(pend, p); exp.push_back(k); pend[k] = 1'b0; p = (k + 1) % N; end
    end
    req_i = 3'b011;
    wait_acks(2, 100, ok);
    req_i = 3'b011;
    wait_acks(4, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL alt_acks: got %0d acks want 4", aq.size()); end
    if (ok) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++; if (gq[i].idx != exp[i]) begin n_fail++; $display("FAIL alt_gnt[%0d]: got %0d want %0d", i, gq[i].idx, exp[i]); end
        n_cmp++; if (aq[i].idx != exp[i] || aq[i].rd !== (wr_data_i[32*exp[i] +: 32] ^ m_key)) begin
          n_fail++; $display("FAIL alt_ack[%0d]: got %0d/%h want %0d/%h", i, aq[i].idx, aq[i].rd,
                              exp[i], wr_data_i[32*exp[i] +: 32] ^ m_key); end
      end
    end
    model_ptr = p;
  endtask

  task automatic test_rr_fair();
    bit ok;
    int k0, k1, k2;
    gq.delete(); aq.delete();
    m_len_fix = 20;
    k0 = rr_pick(3'b001, model_ptr);
    k1 = rr_pick(3'b011, (k0 + 1) % N);
    k2 = rr_pick(3'b001, (k1 + 1) % N);
    req_i = 3'b001;
    wait_grants(1, 20, ok);
    repeat (3) step();
    req_i[1] = 1'b1;
    wait_acks(1, 100, ok);
    req_i[0] = 1'b1;
    wait_acks(3, 200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL fair_acks: got %0d acks want 3", aq.size()); end
    if (ok) begin
      n_cmp++; if (gq[0].idx != k0) begin n_fail++; $display("FAIL fair_first: got %0d want %0d", gq[0].idx, k0); end
      n_cmp++; if (gq[1].idx != k1) begin n_fail++; $display("FAIL fair_second: got %0d want %0d", gq[1].idx, k1); end
      n_cmp++; if (gq[2].idx != k2) begin n_fail++; $display("FAIL fair_third: got %0d want %0d", gq[2].idx, k2); end
    end
    model_ptr = (k2 + 1) % N;
  endtask

  task automatic test_withdraw();
    bit ok;
    gq.delete(); aq.delete();
    m_len_fix = 20;
    req_i = 3'b001;
    wait_grants(1, 20, ok);
    repeat (2) step();
    req_i[1] = 1'b1;
    repeat (3) step();
    req_i[1] = 1'b0;
    wait_acks(1, 100, ok);
    repeat (15) step();
    n_cmp++; if (gq.size() != 1) begin n_fail++; $display("FAIL withdraw_grants: got %0d want 1", gq.size()); end
    n_cmp++; if (gnt_o !== '0 || spi_start_o !== 1'b0) begin
      n_fail++; $display("FAIL withdraw_idle: got gnt %b start %b want 0 0", gnt_o, spi_start_o); end
    model_ptr = 1;
  endtask

  task automatic test_stale_busy();
    bit ok;
    gq.delete(); aq.delete();
    m_en = 1'b0; spi_busy_i = 1'b1; m_len_fix = 5;
    req_i = 3'b001;
    repeat (6) step();
    n_cmp++; if (gq.size() != 0 || gnt_o !== '0 || spi_start_o !== 1'b0) begin
      n_fail++; $display("FAIL stale_busy_nogrant: got grants %0d gnt %b want 0 0", gq.size(), gnt_o); end
    spi_busy_i = 1'b0; m_en = 1'b1;
    wait_acks(1, 50, ok);
    n_cmp++; if (!ok || aq[0].idx != 0 || aq[0].rd !== (wr_data_i[31:0] ^ m_key)) begin
      n_fail++; $display("FAIL stale_busy_after: got ok %0d rd %h want 1 %h", ok, rd_data_o, wr_data_i[31:0] ^ m_key); end
    model_ptr = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b;
    gq.delete(); aq.delete();
    m_len_fix = 30;
    req_i = 3'b001;
    wait_grants(1, 20, ok);
    b = 0;
    while (!spi_busy_i && b < 20) begin step(); b++; end
    repeat (3) step();
    RST = 1'b0;
    #1;
    n_cmp++; if (gnt_o !== '0 || ack_o !== '0 || err_o !== 1'b0 || spi_start_o !== 1'b0) begin
      n_fail++; $display("FAIL midrst_ctrl: got gnt %b ack %b err %b start %b want 0", gnt_o, ack_o, err_o, spi_start_o); end
    n_cmp++; if (rd_data_o !== '0 || spi_mosi_data_o !== '0 || {spi_mode_o, spi_speed_o, spi_word_len_o} !== 6'd0) begin
      n_fail++; $display("FAIL midrst_data: got rd %h mosi %h want 0 0", rd_data_o, spi_mosi_data_o); end
    m_en = 1'b0; spi_busy_i = 1'b0; m_cnt = 0;
    repeat (2) step();
    n_cmp++; if (aq.size() != 0) begin n_fail++; $display("FAIL midrst_noack: got %0d acks want 0", aq.size()); end
    RST = 1'b1; model_ptr = 0; m_en = 1'b1; m_key = $urandom;
    gq.delete(); aq.delete();
    req_i = 3'b001;
    wait_acks(1, 100, ok);
    n_cmp++; if (!ok || gq[0].idx != 0 || aq[0].rd !== (wr_data_i[31:0] ^ m_key)) begin
      n_fail++; $display("FAIL midrst_regrant: got ok %0d rd %h want 1 %h", ok, rd_data_o, wr_data_i[31:0] ^ m_key); end
    model_ptr = 1;
  endtask

  task automatic test_random();
    bit ok;
    int exp[$];
    int p;
    logic [N-1:0] pend;
    m_len_fix = 0;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N; k++) begin cfg_i[6*k +: 6] = 6'($urandom); wr_data_i[32*k +: 32] = $urandom; end
      m_key = $urandom;
      pend = N'($urandom_range(1, (1 << N) - 1));
      exp.delete(); gq.delete(); aq.delete();
      p = model_ptr;
      req_i = pend;
      while (pend != '0) begin int k; k = rr_pick(pend, p); exp.push_back(k); pend[k] = 1'b0; p = (k + 1) % N; end
      wait_acks(exp.size(), 50 * N, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL rand_acks[%0d]: got %0d want %0d", r, aq.size(), exp.size()); end
      if (ok) begin
        for (int i = 0; i < exp.size(); i++) begin
          int k;
          k = exp[i];
          n_cmp++; if (gq[i].idx != k || {gq[i].mode, gq[i].speed, gq[i].len} !== cfg_i[6*k +: 6] ||
                       gq[i].mosi !== wr_data_i[32*k +: 32]) begin
            n_fail++; $display("FAIL rand_gnt[%0d.%0d]: got %0d/%b/%h want %0d/%b/%h", r, i, gq[i].idx,
                                {gq[i].mode, gq[i].speed, gq[i].len}, gq[i].mosi, k, cfg_i[6*k +: 6], wr_data_i[32*k +: 32]); end
          n_cmp++; if (aq[i].idx != k || aq[i].rd !== (wr_data_i[32*k +: 32] ^ m_key) || aq[i].err !== 1'b0) begin
            n_fail++; $display("FAIL rand_ack[%0d.%0d]: got %0d/%h/%b want %0d/%h/0", r, i, aq[i].idx, aq[i].rd,
                                aq[i].err, k, wr_data_i[32*k +: 32] ^ m_key); end
        end
      end
      model_ptr = p;
      step();
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    gq.delete(); aq.delete();
    m_en = 1'b0; spi_busy_i = 1'b0;
    req_i = 3'b001;
    wait_acks(1, 300, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL timeout_ack: got no ack want ack"); end
    if (ok) begin
      n_cmp++; if (aq[0].cyc - gq[0].cyc != TO) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", aq[0].cyc - gq[0].cyc, TO); end
      n_cmp++; if (aq[0].idx != 0 || aq[0].err !== 1'b1 || aq[0].rd !== '0 || aq[0].start !== 1'b0) begin
        n_fail++; $display("FAIL timeout_flags: got idx %0d err %b rd %h start %b want 0 1 0 0", aq[0].idx, aq[0].err, aq[0].rd, aq[0].start); end
    end
    step();
    n_cmp++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b want 0", err_o); end
    m_en = 1'b1; m_len_fix = 10; aq.delete(); gq.delete();
    req_i = 3'b001;
    wait_acks(1, 100, ok);
    n_cmp++; if (!ok || aq[0].err !== 1'b0 || aq[0].rd !== (wr_data_i[31:0] ^ m_key)) begin
      n_fail++; $display("FAIL timeout_next: got ok %0d rd %h want 1 %h", ok, rd_data_o, wr_data_i[31:0] ^ m_key); end
  endtask
`endif

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; model_ptr = 0; prev_gnt = '0;
    m_en = 1'b1; m_cnt = 0; m_len_fix = 0; m_key = '0; m_mosi = '0;
    RST = 1'b0; req_i = '0; cfg_i = '0; wr_data_i = '0;
    spi_busy_i = 1'b0; spi_miso_data_i = '0;
    test_reset();
    test_single();
    test_alternate();
    test_rr_fair();
    test_withdraw();
    test_stale_busy();
    test_reset_mid();
    test_random();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
